// File: rtl/stack_op_sequencer_if.sv
// Bundle of command, RAM and display signals around the stack sequencer.
// master is the sequencer side; slave is the buttons/RAM/display side.
interface stack_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             push_pulse;
    logic             pop_pulse;
    logic             add_pulse;
    logic             sub_pulse;
    logic [WIDTH-1:0] switch;
    logic [WIDTH-1:0] mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] top;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             busy;
    logic             error;

    modport master (
        input  push_pulse, pop_pulse, add_pulse, sub_pulse, switch, mem_rdata,
        output mem_addr, mem_we, mem_wdata, top, count, empty, full, busy, error
    );

    modport slave (
        output push_pulse, pop_pulse, add_pulse, sub_pulse, switch, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, top, count, empty, full, busy, error
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Stack calculator sequencer: turns push/pop/add/sub pulses into RAM cycles
// on an external synchronous stack RAM and keeps the pointer and a cached top.
module stack_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_op_sequencer_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PUSH_WR = 3'd1;
    localparam logic [2:0] POP_RD  = 3'd2;
    localparam logic [2:0] POP_LD  = 3'd3;
    localparam logic [2:0] AR_RD   = 3'd4;
    localparam logic [2:0] AR_LD   = 3'd5;
    localparam logic [2:0] AR_WR   = 3'd6;

    logic [2:0]       state;
    logic [AW:0]      count;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;
    logic             is_sub;
    logic             err;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;

    logic             any_cmd;
    logic             do_push;
    logic             do_pop;
    logic             legal;
    logic             two_plus;
    logic [AW:0]      below_top;
    logic [WIDTH-1:0] alu;

    always_comb begin
        any_cmd   = bus.push_pulse | bus.pop_pulse | bus.add_pulse | bus.sub_pulse;
        do_push   = bus.push_pulse;
        do_pop    = !bus.push_pulse && bus.pop_pulse;
        two_plus  = (count >= (AW+1)'(2));
        below_top = count - (AW+1)'(2);
        if (do_push)
            legal = (count != (AW+1)'(DEPTH));
        else if (do_pop)
            legal = (count != '0);
        else
            legal = two_plus;
        // Second-from-top is the left operand of subtraction.
        alu = is_sub ? (bus.mem_rdata - tos) : (bus.mem_rdata + tos);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            tos     <= '0;
            operand <= '0;
            result  <= '0;
            is_sub  <= 1'b0;
            err     <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_cmd) begin
                        operand <= bus.switch;
                        err     <= !legal;
                        if (legal) begin
                            if (do_push) begin
                                state <= PUSH_WR;
                                we    <= 1'b1;
                                addr  <= count[AW-1:0];
                                wdata <= bus.switch;
                            end else if (do_pop) begin
                                state <= POP_RD;
                                addr  <= two_plus ? below_top[AW-1:0] : '0;
                            end else begin
                                state  <= AR_RD;
                                is_sub <= !bus.add_pulse;
                                addr   <= below_top[AW-1:0];
                            end
                        end
                    end
                end
                PUSH_WR: begin
                    tos   <= operand;
                    count <= count + (AW+1)'(1);
                    state <= IDLE;
                end
                POP_RD: state <= POP_LD;
                POP_LD: begin
                    // Popping the last entry leaves nothing to show.
                    tos   <= two_plus ? bus.mem_rdata : '0;
                    count <= count - (AW+1)'(1);
                    state <= IDLE;
                end
                AR_RD: state <= AR_LD;
                AR_LD: begin
                    result <= alu;
                    wdata  <= alu;
                    we     <= 1'b1;
                    state  <= AR_WR;
                end
                AR_WR: begin
                    tos   <= result;
                    count <= count - (AW+1)'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = addr;
    assign bus.mem_we    = we;
    assign bus.mem_wdata = wdata;
    assign bus.top       = tos;
    assign bus.count     = count;
    assign bus.empty     = (count == '0);
    assign bus.full      = (count == (AW+1)'(DEPTH));
    assign bus.busy      = (state != IDLE);
    assign bus.error     = err;
endmodule

// File: doc/stack_op_sequencer.md
# stack_op_sequencer

Sequences the stack calculator datapath: accepts one-cycle command pulses from the debounced push/pop/add/subtract buttons, drives an external single-port synchronous stack RAM, and maintains the stack pointer and a registered top-of-stack value for the seven-segment display driver. It sits between the button debouncers and switch inputs on one side and the stack RAM and display on the other, and is the only master of the RAM.

## Interface
- WIDTH, 8: data width of stack entries and SWITCH.
- DEPTH, 16: stack entries; power of two.
- AW, log2(DEPTH): RAM address width (derived).

- CLK  in  1  system clock (100 MHz)
- RESET  in  1  asynchronous, active-high reset
- PUSH_PULSE / POP_PULSE / ADD_PULSE / SUB_PULSE  in  1 each  debounced one-cycle command pulses
- SWITCH  in  WIDTH  operand for PUSH
- MEM_RDATA  in  WIDTH  RAM read data, valid one cycle after MEM_ADDR with MEM_WE=0
- MEM_ADDR  out  AW  RAM address
- MEM_WE  out  1  RAM write enable
- MEM_WDATA  out  WIDTH  RAM write data
- TOP  out  WIDTH  current top-of-stack value; 0 when empty
- COUNT  out  AW+1  entries on stack, 0..DEPTH
- EMPTY / FULL  out  1 each  COUNT==0 / COUNT==DEPTH
- BUSY  out  1  high whenever state != IDLE
- ERROR  out  1  last command was illegal; sticky until next accepted legal command

## Operation
- Reset values: state IDLE, COUNT 0, TOP 0, EMPTY 1, FULL 0, BUSY 0, ERROR 0, MEM_WE 0, MEM_ADDR 0, MEM_WDATA 0. RAM contents are not cleared.
- Stack layout: entry i at address i; top at COUNT-1.
- Commands are accepted only in IDLE. Pulses arriving while BUSY are dropped.
- Simultaneous pulses resolve by priority PUSH > POP > ADD > SUB; lower-priority commands are dropped.
- On acceptance, SWITCH is captured into the operand register.
- Legality rules:
  - PUSH requires !FULL.
  - POP requires !EMPTY.
  - ADD and SUB require COUNT>=2.
- Illegal command: ERROR<=1 on the accept edge; state stays IDLE; COUNT, TOP and RAM are unchanged; no BUSY cycle.
- Legal command: ERROR<=0 on the accept edge.
- States: IDLE, PUSH_WR, POP_RD, POP_LD, AR_RD, AR_LD, AR_WR.
- PUSH: IDLE→PUSH_WR. In PUSH_WR: MEM_WE=1, MEM_ADDR=COUNT, MEM_WDATA=operand. On exit: TOP<=operand, COUNT++, →IDLE.
- POP: IDLE→POP_RD→POP_LD→IDLE.
  - In POP_RD: MEM_ADDR=COUNT-2, clamped to 0 when COUNT==1.
  - In POP_LD: TOP<=MEM_RDATA if COUNT>=2, else 0; COUNT--.
- ADD/SUB: IDLE→AR_RD→AR_LD→AR_WR→IDLE.
  - In AR_RD: MEM_ADDR=COUNT-2.
  - In AR_LD: result register <= MEM_RDATA+TOP (ADD) or MEM_RDATA−TOP (SUB), second-from-top minus top.
  - In AR_WR: MEM_WE=1, MEM_ADDR=COUNT-2, MEM_WDATA=result. On exit: TOP<=result, COUNT--.
- Arithmetic is modulo 2^WIDTH; no carry or borrow flag.
- MEM_WE is high only in PUSH_WR and AR_WR. Outside write states, MEM_WDATA holds its last value.

## Timing
- All outputs are registered or Moore-decoded from registered state; there are no combinational input-to-output paths.
- PUSH: BUSY 1 cycle. TOP and COUNT update at the edge ending PUSH_WR, 2 edges after the pulse is sampled.
- POP: BUSY 2 cycles. TOP and COUNT update 3 edges after the pulse is sampled.
- ADD/SUB: BUSY 3 cycles; exactly one MEM_WE cycle. TOP and COUNT update 4 edges after the pulse is sampled.
- A new command is accepted in the first IDLE cycle after BUSY falls. Back-to-back PUSH pulses spaced 2 cycles apart are both accepted.
- ERROR updates on the accept edge, 1 edge after the pulse is sampled.
- RESET mid-operation forces reset values immediately (asynchronously), including MEM_WE=0. The in-flight operation is abandoned with no write after deassertion.
- Wrap-around: COUNT never exceeds DEPTH or goes below 0. MEM_ADDR never exceeds DEPTH-1.

## Test plan
- Reset, then PUSH with SWITCH=0x05, then PUSH with SWITCH=0x03 → writes addr0=0x05 and addr1=0x03, each with one MEM_WE cycle; TOP=0x03, COUNT=2, ERROR=0.
- From that state, ADD → BUSY for 3 cycles, one write addr0=0x08; TOP=0x08, COUNT=1. Separately, stack [0x02,0x05] (0x05 on top) then SUB → TOP=0xFD, COUNT=1.
- COUNT=1, POP → COUNT=0, TOP=0, EMPTY=1. Second POP → ERROR=1, COUNT=0, no BUSY. ADD with COUNT=1 → ERROR=1. A following PUSH clears ERROR.
- 16 PUSHes of 0x10..0x1F → FULL=1, TOP=0x1F. 17th PUSH → ERROR=1, no MEM_WE, COUNT=16.
- All four pulses in the same cycle with SWITCH=0xAA → only PUSH performed (TOP=0xAA). A POP pulse during PUSH_WR is dropped (COUNT +1 only).
- RESET asserted during AR_LD → outputs reach reset values before the next edge; after release, no MEM_WE occurs and COUNT=0.
